// File: rtl/mouse_init_ctrl.sv
// PS/2 mouse bring-up controller: waits out mouse power-up, sends reset (FF),
// checks ACK/self-test/ID, enables streaming (F4), then assembles 3-byte
// movement packets. Failed attempts are retried; too many failures latch ERROR.
module mouse_init_ctrl #(
   parameter logic [23:0] POWERUP_CYCLES = 24'd5_000_000,
   parameter logic [23:0] TIMEOUT_CYCLES = 24'd10_000_000,
   parameter int unsigned MAX_RETRIES    = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        idle_status,
   input  logic        done_writing,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic        write_to_mouse,
   output logic [7:0]  data_to_write,
   output logic        init_done,
   output logic        init_error,
   output logic        packet_valid,
   output logic [23:0] packet_data
);

   typedef enum logic [3:0] {
      StPowerup, StSendRst, StWrRst, StAckRst, StSelftest, StId,
      StSendEn, StWrEn, StAckEn, StStream, StError
   } state_e;

   state_e      r_state, w_state_d;
   logic [23:0] r_cnt, w_cnt_d;
   logic [7:0]  r_retry, w_retry_inc;
   logic        r_write, w_wr_req;
   logic [7:0]  r_data, w_wr_byte;
   logic        w_fail, w_count_en, w_pwr_done, w_timeout;
   logic [1:0]  r_idx;
   logic [7:0]  r_byte0, r_byte1;
   logic        r_pkt_valid;
   logic [23:0] r_pkt_data;

   // One shared counter: power-up delay in POWERUP, timeout in the wait states.
   assign w_pwr_done  = ({8'd0, r_cnt} + 32'd1) >= {8'd0, POWERUP_CYCLES};
   assign w_timeout   = ({8'd0, r_cnt} + 32'd1) >= {8'd0, TIMEOUT_CYCLES};
   assign w_retry_inc = r_retry + 8'd1;

   // Next-state, write request and failure detection.
   always_comb begin
      w_state_d  = r_state;
      w_fail     = 1'b0;
      w_wr_req   = 1'b0;
      w_wr_byte  = 8'h00;
      w_count_en = 1'b0;
      case (r_state)
         StPowerup: begin
            w_count_en = 1'b1;
            if (w_pwr_done) w_state_d = StSendRst;
         end
         StSendRst: begin
            if (idle_status) begin
               w_wr_req  = 1'b1;
               w_wr_byte = 8'hFF;
               w_state_d = StWrRst;
            end
         end
         StSendEn: begin
            if (idle_status) begin
               w_wr_req  = 1'b1;
               w_wr_byte = 8'hF4;
               w_state_d = StWrEn;
            end
         end
         StWrRst, StWrEn: begin
            w_count_en = 1'b1;
            if (done_writing) w_state_d = (r_state == StWrRst) ? StAckRst : StAckEn;
            else if (w_timeout) w_fail = 1'b1;
         end
         StAckRst, StAckEn: begin
            w_count_en = 1'b1;
            if (rx_valid) begin
               if (rx_data == 8'hFA) w_state_d = (r_state == StAckRst) ? StSelftest : StStream;
               else if (rx_data == 8'hFE) w_state_d = (r_state == StAckRst) ? StSendRst : StSendEn;
               else w_fail = 1'b1;
            end else if (w_timeout) begin
               w_fail = 1'b1;
            end
         end
         StSelftest: begin
            w_count_en = 1'b1;
            if (rx_valid) begin
               if (rx_data == 8'hAA) w_state_d = StId;
               else w_fail = 1'b1;
            end else if (w_timeout) begin
               w_fail = 1'b1;
            end
         end
         StId: begin
            w_count_en = 1'b1;
            if (rx_valid) w_state_d = StSendEn;
            else if (w_timeout) w_fail = 1'b1;
         end
         StStream, StError: ;
         default: w_state_d = StPowerup;
      endcase
      if (w_fail) w_state_d = ({24'd0, w_retry_inc} < MAX_RETRIES) ? StSendRst : StError;
      // Every failure or success leaves the state, so "state change" doubles as counter clear.
      if (!w_count_en || (w_state_d != r_state)) w_cnt_d = '0;
      else w_cnt_d = r_cnt + 24'd1;
   end

   // Control state, counters and the registered write request.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= StPowerup;
         r_cnt   <= '0;
         r_retry <= '0;
         r_write <= 1'b0;
         r_data  <= 8'h00;
      end else begin
         r_state <= w_state_d;
         r_cnt   <= w_cnt_d;
         r_write <= w_wr_req;
         if (w_wr_req) r_data <= w_wr_byte;
         if (w_fail) r_retry <= w_retry_inc;
      end
   end

   // Packet assembly in STREAM; byte 0 must carry the always-one bit 3 to resync.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_idx       <= 2'd0;
         r_byte0     <= 8'h00;
         r_byte1     <= 8'h00;
         r_pkt_valid <= 1'b0;
         r_pkt_data  <= 24'h0;
      end else begin
         r_pkt_valid <= 1'b0;
         if (r_state == StStream && rx_valid) begin
            case (r_idx)
               2'd0: begin
                  if (rx_data[3]) begin
                     r_byte0 <= rx_data;
                     r_idx   <= 2'd1;
                  end
               end
               2'd1: begin
                  r_byte1 <= rx_data;
                  r_idx   <= 2'd2;
               end
               default: begin
                  r_pkt_data  <= {rx_data, r_byte1, r_byte0};
                  r_pkt_valid <= 1'b1;
                  r_idx       <= 2'd0;
               end
            endcase
         end
      end
   end

   assign write_to_mouse = r_write;
   assign data_to_write  = r_data;
   assign init_done      = (r_state == StStream);
   assign init_error     = (r_state == StError);
   assign packet_valid   = r_pkt_valid;
   assign packet_data    = r_pkt_data;

endmodule

// File: tb/tb_mouse_init_ctrl.sv
// Scoreboard bench for mouse_init_ctrl: stimulus pushes expected writes and
// packets; a negedge monitor pops and compares whenever the DUT presents them.
module tb_mouse_init_ctrl;

   localparam logic [23:0] PWR     = 24'd40;
   localparam logic [23:0] TMO     = 24'd100;
   localparam int unsigned RETRIES = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        idle_status = 1'b0;
   logic        done_writing = 1'b0;
   logic        rx_valid = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        write_to_mouse;
   logic [7:0]  data_to_write;
   logic        init_done;
   logic        init_error;
   logic        packet_valid;
   logic [23:0] packet_data;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int rel_cyc = 0;
   int writes_seen = 0;
   int dones_seen = 0;
   bit auto_done = 1'b1;
   logic prev_write = 1'b0;

   logic [7:0]  exp_wr[$];
   logic [23:0] exp_pkt[$];
   logic [7:0]  pkt_q[$];
   logic [23:0] last_pkt = 24'h0;
   int wr_cycs[$];
   int done_cycs[$];

   mouse_init_ctrl #(
      .POWERUP_CYCLES(PWR),
      .TIMEOUT_CYCLES(TMO),
      .MAX_RETRIES   (RETRIES)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .idle_status   (idle_status),
      .done_writing  (done_writing),
      .rx_valid      (rx_valid),
      .rx_data       (rx_data),
      .write_to_mouse(write_to_mouse),
      .data_to_write (data_to_write),
      .init_done     (init_done),
      .init_error    (init_error),
      .packet_valid  (packet_valid),
      .packet_data   (packet_data)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   // Monitor: pops the scoreboard whenever the DUT issues a write or a packet.
   initial forever begin
      @(negedge clk);
      if (rst_n) begin
         if (done_writing) done_cycs.push_back(cyc);
         if (write_to_mouse) begin
            writes_seen++;
            wr_cycs.push_back(cyc);
            chk("write_not_back_to_back", 32'(prev_write), 32'd0);
            if (exp_wr.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write: got %0h, required no write", data_to_write);
            end else begin
               chk("write_byte", 32'(data_to_write), 32'(exp_wr.pop_front()));
            end
         end
         if (packet_valid) begin
            if (exp_pkt.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_packet: got %0h, required no packet", packet_data);
            end else begin
               chk("packet_data", 32'(packet_data), 32'(exp_pkt.pop_front()));
            end
         end
      end
      prev_write = write_to_mouse;
   end

   // Writer model: acknowledges each write request after a random delay.
   initial forever begin
      @(negedge clk);
      if (write_to_mouse && auto_done && rst_n) begin
         repeat ($urandom_range(1, 4)) @(posedge clk);
         #1 done_writing = 1'b1;
         @(posedge clk);
         #1 done_writing = 1'b0;
         dones_seen++;
      end
   end

   initial begin
      #800000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_rx(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      tick(1);
      rx_valid = 1'b0;
   endtask

   task automatic wait_dones(input int tgt, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (dones_seen >= tgt) begin
            ok = 1'b1;
            break;
         end
         tick(1);
      end
   endtask

   // Push an expected write and wait for the writer to finish it.
   task automatic expect_write(input logic [7:0] b, input string name);
      bit ok;
      int tgt;
      exp_wr.push_back(b);
      tgt = dones_seen + 1;
      wait_dones(tgt, 400, ok);
      chk(name, 32'(ok), 32'd1);
      tick(2);
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      tick(3);
      chk("rst_write", 32'(write_to_mouse), 32'd0);
      chk("rst_data", 32'(data_to_write), 32'h00);
      chk("rst_init_done", 32'(init_done), 32'd0);
      chk("rst_init_error", 32'(init_error), 32'd0);
      chk("rst_packet_valid", 32'(packet_valid), 32'd0);
      chk("rst_packet_data", 32'(packet_data), 32'h0);
      pkt_q.delete();
      wr_cycs.delete();
      done_cycs.delete();
      rst_n   = 1'b1;
      rel_cyc = cyc;
   endtask

   // Reference packet framer: byte 0 needs bit 3 set, then any two bytes.
   task automatic feed_stream(input logic [7:0] b);
      if (pkt_q.size() != 0 || b[3]) pkt_q.push_back(b);
      if (pkt_q.size() == 3) begin
         last_pkt = {pkt_q[2], pkt_q[1], pkt_q[0]};
         exp_pkt.push_back(last_pkt);
         pkt_q.delete();
      end
      send_rx(b);
   endtask

   task automatic random_stream(input int n);
      for (int i = 0; i < n; i++) begin
         feed_stream(8'($urandom));
         tick($urandom_range(0, 2));
      end
      tick(3);
      chk("stream_hold", 32'(packet_data), 32'(last_pkt));
      chk("stream_drained", exp_pkt.size(), 32'd0);
   endtask

   // Random init session; the model counts failed attempts against RETRIES.
   task automatic init_session();
      int fails;
      int ph;
      int r;
      bit fin;
      bit failed;
      bit to_err;
      bit ok;
      int tgt;
      logic [7:0] b;
      fails  = 0;
      ph     = 0;
      fin    = 1'b0;
      to_err = 1'b0;
      while (!fin) begin
         failed = 1'b0;
         exp_wr.push_back((ph == 0) ? 8'hFF : 8'hF4);
         tgt = dones_seen + 1;
         wait_dones(tgt, 400, ok);
         chk("sess_write_done", 32'(ok), 32'd1);
         if (!ok) return;
         tick($urandom_range(0, 4));
         r = int'($urandom_range(0, 9));
         if (r < 6) begin
            send_rx(8'hFA);
            if (ph == 1) begin
               fin = 1'b1;
            end else begin
               tick($urandom_range(0, 3));
               if ($urandom_range(0, 9) < 8) begin
                  send_rx(8'hAA);
                  tick($urandom_range(0, 3));
                  send_rx(8'($urandom));
                  ph = 1;
               end else begin
                  b = 8'($urandom);
                  while (b == 8'hAA) b = 8'($urandom);
                  send_rx(b);
                  failed = 1'b1;
               end
            end
         end else if (r < 8) begin
            send_rx(8'hFE);
         end else begin
            b = 8'($urandom);
            while (b == 8'hFA || b == 8'hFE) b = 8'($urandom);
            send_rx(b);
            failed = 1'b1;
         end
         if (failed) begin
            fails++;
            if (fails >= int'(RETRIES)) begin
               to_err = 1'b1;
               fin    = 1'b1;
            end else begin
               ph = 0;
            end
         end
      end
      tick(3);
      chk("sess_init_done", 32'(init_done), 32'(!to_err));
      chk("sess_init_error", 32'(init_error), 32'(to_err));
      if (!to_err) random_stream(12);
   endtask

   initial begin
      int w0;
      tick(1);

      // Normal init; writer busy at first, junk bytes during power-up.
      idle_status = 1'b0;
      apply_reset();
      send_rx(8'hFA);
      send_rx(8'hFE);
      w0 = writes_seen;
      tick(int'(PWR) + 10);
      chk("no_write_while_busy", writes_seen - w0, 32'd0);
      idle_status = 1'b1;
      expect_write(8'hFF, "norm_ff_done");
      send_rx(8'hFA);
      tick(1);
      send_rx(8'hAA);
      send_rx(8'h00);
      expect_write(8'hF4, "norm_f4_done");
      send_rx(8'hFA);
      tick(2);
      chk("norm_init_done", 32'(init_done), 32'd1);
      chk("norm_init_error", 32'(init_error), 32'd0);

      // Stream sync: 00 is dropped, 09 12 34 form one packet.
      feed_stream(8'h00);
      feed_stream(8'h09);
      feed_stream(8'h12);
      feed_stream(8'h34);
      tick(3);
      chk("sync_packet", 32'(packet_data), 32'h341209);
      random_stream(30);

      // Reset after two bytes of a packet: no packet may appear.
      while (pkt_q.size() != 2) feed_stream(8'($urandom) | 8'h08);
      tick(2);
      apply_reset();

      // Resend: FE three times in ACK_RST and once in ACK_EN never counts as a retry.
      expect_write(8'hFF, "rs_ff0_done");
      for (int i = 0; i < 3; i++) begin
         send_rx(8'hFE);
         expect_write(8'hFF, "rs_ff_again_done");
      end
      send_rx(8'hFA);
      send_rx(8'hAA);
      send_rx(8'h03);
      expect_write(8'hF4, "rs_f4_done");
      send_rx(8'hFE);
      expect_write(8'hF4, "rs_f4_again_done");
      send_rx(8'hFA);
      tick(2);
      chk("rs_init_done", 32'(init_done), 32'd1);
      chk("rs_init_error", 32'(init_error), 32'd0);
      random_stream(20);

      // Reset while waiting in WR_EN; rx there is ignored and data is held.
      apply_reset();
      expect_write(8'hFF, "wr_ff_done");
      send_rx(8'hFA);
      send_rx(8'hAA);
      auto_done = 1'b0;
      exp_wr.push_back(8'hF4);
      w0 = writes_seen;
      send_rx(8'h00);
      for (int i = 0; i < 50 && writes_seen == w0; i++) tick(1);
      chk("wr_f4_issued", writes_seen - w0, 32'd1);
      tick(3);
      chk("wr_data_held", 32'(data_to_write), 32'hF4);
      send_rx(8'hFA);
      tick(2);
      chk("wr_rx_ignored", 32'(init_done), 32'd0);
      chk("wr_data_held2", 32'(data_to_write), 32'hF4);
      apply_reset();
      auto_done = 1'b1;

      // Randomized init sessions against the retry model.
      init_session();
      for (int s = 0; s < 5; s++) begin
         apply_reset();
         init_session();
      end

      // Timeouts: no rx at all, so three attempts then ERROR.
      apply_reset();
      exp_wr.push_back(8'hFF);
      exp_wr.push_back(8'hFF);
      exp_wr.push_back(8'hFF);
      w0 = writes_seen;
      for (int i = 0; i < 1500 && !init_error; i++) tick(1);
      chk("to_init_error", 32'(init_error), 32'd1);
      tick(200);
      chk("to_write_count", writes_seen - w0, 32'd3);
      chk("to_init_done", 32'(init_done), 32'd0);
      if (wr_cycs.size() >= 3 && done_cycs.size() >= 2) begin
         chk("to_powerup_delay", wr_cycs[0] - rel_cyc, int'(PWR) + 1);
         chk("to_gap1", wr_cycs[1] - done_cycs[0], int'(TMO) + 2);
         chk("to_gap2", wr_cycs[2] - done_cycs[1], int'(TMO) + 2);
      end else begin
         chk("to_event_count", wr_cycs.size(), 32'd3);
      end
      send_rx(8'hFA);
      tick(5);
      chk("to_error_sticky", 32'(init_error), 32'd1);

      chk("final_wr_queue", exp_wr.size(), 32'd0);
      chk("final_pkt_queue", exp_pkt.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mouse_init_ctrl.md
MOUSE_INIT_CTRL -- requirements
Module: mouse_init_ctrl

Interface
REQ-001 The block SHALL have parameter POWERUP_CYCLES, default 24'd5_000_000, meaning idle cycles after reset before the first command.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 24'd10_000_000, meaning the maximum cycles spent in any wait state.
REQ-003 The block SHALL have parameter MAX_RETRIES, default 3, meaning full init attempts before error.
REQ-004 The block SHALL have port clk, input, 1 bit: system clock; one clock only, all logic on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 The block SHALL have port idle_status, input, 1 bit: the PS/2 writer is idle.
REQ-007 The block SHALL have port done_writing, input, 1 bit: one-cycle pulse, the writer finished a byte.
REQ-008 The block SHALL have port rx_valid, input, 1 bit: one-cycle pulse, rx_data holds a received byte.
REQ-009 The block SHALL have port rx_data, input, 8 bits: byte from the PS/2 receiver.
REQ-010 The block SHALL have port write_to_mouse, output, 1 bit: one-cycle write request to the writer.
REQ-011 The block SHALL have port data_to_write, output, 8 bits: command byte for the writer.
REQ-012 The block SHALL have port init_done, output, 1 bit: high while in STREAM.
REQ-013 The block SHALL have port init_error, output, 1 bit: high while in ERROR; sticky until reset.
REQ-014 The block SHALL have port packet_valid, output, 1 bit: one-cycle pulse, packet_data is complete.
REQ-015 The block SHALL have port packet_data, output, 24 bits: {byte2, byte1, byte0}, with byte0 the status byte.

Function
REQ-016 States SHALL be POWERUP, SEND_RST, WR_RST, ACK_RST, SELFTEST, ID, SEND_EN, WR_EN, ACK_EN, STREAM and ERROR.
REQ-017 Transitions SHALL be as follows:
- POWERUP: counts POWERUP_CYCLES, then goes to SEND_RST.
- SEND_RST: waits for idle_status=1, then drives data_to_write=8'hFF, pulses write_to_mouse for exactly one cycle and goes to WR_RST.
- SEND_EN: same as SEND_RST with 8'hF4, then goes to WR_EN.
REQ-018 WR_RST/WR_EN SHALL wait for done_writing, then go to ACK_RST/ACK_EN; data_to_write SHALL stay stable from the request cycle until done_writing.
REQ-019 In ACK_RST/ACK_EN, rx_valid with the following rx_data SHALL cause the following transition:
- 8'hFA: go to SELFTEST (from ACK_RST) or STREAM (from ACK_EN).
- 8'hFE: return to SEND_RST or SEND_EN (resend the same command, no retry increment).
- Any other byte: failure.
REQ-020 In SELFTEST, rx 8'hAA SHALL go to ID; any other byte SHALL be a failure.
REQ-021 In ID, any received byte SHALL go to SEND_EN.
REQ-022 A timeout counter SHALL clear on every state entry and count in WR_*, ACK_*, SELFTEST and ID; reaching TIMEOUT_CYCLES-1 SHALL be a failure.
REQ-023 On failure, retry_cnt SHALL increment, and the block SHALL go to SEND_RST if the new count < MAX_RETRIES, else to ERROR.
REQ-024 ERROR SHALL be terminal until rst_n=0; no write requests SHALL be issued in ERROR.
REQ-025 Bytes arriving by rx_valid in POWERUP, SEND_* or WR_* SHALL be ignored.
REQ-026 In STREAM, received bytes SHALL be assembled into a 3-byte packet:
- Index 0 is accepted only if rx_data[3]=1; otherwise the byte is discarded and the index stays 0.
- Indices 1 and 2 are stored unconditionally.
- After the third byte, packet_valid pulses on the next cycle with packet_data, and the index wraps to 0.
REQ-027 packet_data SHALL hold its value until the next packet completes.
REQ-028 There SHALL be no timeout in STREAM.
REQ-029 write_to_mouse SHALL never be high for two consecutive cycles.

Reset
REQ-030 While rst_n=0 at a clk edge, the block SHALL enter the following reset state:
- state=POWERUP; all counters and the packet index are 0.
- write_to_mouse=0, data_to_write=8'h00.
- init_done=0, init_error=0.
- packet_valid=0, packet_data=24'h0.
REQ-031 Reset mid-operation, including mid-write or mid-packet, SHALL abandon all progress; no partial packet SHALL be emitted after reset.

Verification
REQ-032 The bench SHALL cover a normal init: idle_status=1, done_writing after each request, rx FA, AA, 00, then FA. Required response: writes FF then F4; init_done=1; init_error=0.
REQ-033 The bench SHALL cover resend: rx FE in ACK_RST. Required response: a second FF write; retry_cnt unchanged; init then completes normally.
REQ-034 The bench SHALL cover timeouts: TIMEOUT_CYCLES=100, MAX_RETRIES=3, no rx bytes. Required response: exactly 3 FF writes, then init_error=1 with no further writes.
REQ-035 The bench SHALL cover streaming sync: in STREAM, rx 00, 09, 12, 34. Required response: 00 discarded; one packet_valid pulse with packet_data=24'h341209.
REQ-036 The bench SHALL cover reset mid-operation: rst_n=0 during WR_EN, and separately after 2 bytes of a packet. Required response: all outputs return to reset values; the block restarts from POWERUP; no packet_valid pulse.
